phase_rate_detect: RTL and testbench
====================================

# phase_rate_detect

Receive-side companion to the phase generator. It monitors an 8-bit phase stream in which the phase advances by one (mod 256) every F+1 clocks, and recovers the divider setting F. It reports lock status, flags illegal phase steps, and detects a stalled phase stream. It sits in the wave generator's monitor/loopback path and checks that the generator is running at the commanded rate.

## Interface
- LOCK_COUNT, 4: consecutive identical period measurements required to lock (legal range 1..15).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- phase_in  in  8  observed phase stream, synchronous to clk.
- freq_out  out  8  recovered divider value F (period − 1), valid while locked.
- locked  out  1  level: measured rate is stable and confirmed.
- freq_upd  out  1  one-cycle pulse on lock entry and on each confirming measurement while locked.
- step_err  out  1  one-cycle pulse: phase changed by something other than +1 mod 256.
- stall  out  1  level: no phase change for more than 256 cycles.

## Operation
- phase_q: registered copy of phase_in. Event condition (combinational, cycle t): phase_in != phase_q.
  - Good step: phase_in == phase_q + 1 mod 256. The 255→0 wrap is good.
  - Bad step: any other change.
- dwell_cnt, 9-bit:
  - Loads 1 on an event.
  - Otherwise increments, saturating at 257.
  - At an event, the period is P = dwell_cnt and the measurement is m = P − 1, truncated to 8 bits. The legal P range is 1..256.
- cand (8b) holds the candidate measurement. match (4b) counts consecutive equal measurements.
- States: IDLE, ALIGN, MEASURE, LOCKED.
  - IDLE: on any event → ALIGN. No step check is made in IDLE. The partial period is discarded.
  - ALIGN: on a good event, cand=m, match=1, then → MEASURE; if LOCK_COUNT==1, go directly → LOCKED with the entry actions below. On a bad event, step_err pulse and stay in ALIGN.
  - MEASURE: on a good event with m==cand, match+1. When match reaches LOCK_COUNT → LOCKED: freq_out=cand, locked=1, freq_upd pulse. On a good event with m!=cand, cand=m and match=1. On a bad event, step_err pulse → ALIGN, match=0.
  - LOCKED: on a good event with m==freq_out, freq_upd pulse and stay. On a good event with m!=freq_out, locked=0, cand=m, match=1 → MEASURE. On a bad event, step_err pulse, locked=0 → ALIGN.
- Stall: when dwell_cnt reaches 257 in any state, stall=1, locked=0, match=0, and the state goes → IDLE. stall stays 1 until the next event clears it; that event is then handled by IDLE.
- freq_out holds its last locked value while unlocked and changes only on lock entry.
- A bad step and a period change cannot occur in the same event; the bad-step rule takes priority.

## Timing
- All outputs are registered. For an event in cycle t, state, outputs and pulses are visible from cycle t+1.
- freq_upd and step_err are high for exactly one cycle per qualifying event.
- Reset (asynchronous, any time including mid-lock) gives:
  - State IDLE.
  - phase_q=0, dwell_cnt=0, cand=0, match=0.
  - freq_out=0, locked=0, freq_upd=0, step_err=0, stall=0.
- First clocks after reset release: if phase_in≠0, an event is taken in IDLE and the block enters ALIGN harmlessly.
- With F=0, events occur every cycle with P=1 and m=0; the block must lock normally.
- Lock latency from the first observed step: LOCK_COUNT+1 events. The first event only aligns.

## Test plan
- LOCK_COUNT=4, phase from 0 stepping every 4 clocks (F=3) → ALIGN at the 1st step, then:
  - locked=1 and freq_out=3 one cycle after the 5th step.
  - freq_upd pulse at lock and on every later step.
  - step_err never asserts.
- Phase +1 every clock, spanning the 255→0 wrap → locked=1, freq_out=0, no step_err at the wrap.
- Step every 256 clocks (F=255) → locks with freq_out=255 and stall=0. Then hold phase constant → stall=1 and locked=0 when dwell_cnt hits 257. The next step clears stall.
- While locked at F=3, switch to F=7 →
  - locked=0 one cycle after the first 8-clock period; freq_out stays 3.
  - Relock after 3 more 8-clock periods with freq_out=7.
- While locked, inject a +2 jump → one-cycle step_err and locked=0. Relock after 5 good steps.
- Assert rst_n=0 asynchronously mid-lock → all outputs 0 immediately. After release, relock requires the full LOCK_COUNT+1 steps.

Source files
------------

// File: rtl/phase_rate_detect.sv
// phase_rate_detect
//
// Monitors an 8-bit phase stream that advances by one (mod 256) every F+1
// clocks and recovers the divider setting F. The block reports lock status,
// flags illegal phase steps and detects a stalled stream.
//
// Parameters:
//   LOCK_COUNT  consecutive identical period measurements needed to lock (1..15)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   phase_in  in   [7:0] observed phase stream, synchronous to clk
//   freq_out  out  [7:0] recovered divider value F, updated only on lock entry
//   locked    out  measured rate is stable and confirmed
//   freq_upd  out  one-cycle pulse on lock entry and on each confirming step
//   step_err  out  one-cycle pulse when the phase moves by anything but +1
//   stall     out  phase has not changed for more than 256 cycles
module phase_rate_detect #(
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] phase_in,
  output logic [7:0] freq_out,
  output logic       locked,
  output logic       freq_upd,
  output logic       step_err,
  output logic       stall
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    MEASURE,
    LOCKED
  } state_t;

  localparam logic [8:0] DWELL_SAT   = 9'd257;
  localparam logic [8:0] DWELL_LAST  = 9'd256;
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  state_t     state;
  logic [7:0] phase_q;
  logic [7:0] cand;
  logic [8:0] dwell_cnt;
  logic [3:0] match;

  logic       phase_event;
  logic       good_step;
  logic [7:0] meas;
  logic [3:0] match_inc;
  logic [8:0] dwell_next;

  // The period of the step just observed is the dwell count; the measurement
  // is period-1. A 256-cycle period (dwell 256) truncates to 255 as intended.
  assign phase_event = (phase_in != phase_q);
  assign good_step   = (phase_in == 8'(phase_q + 8'd1));
  assign meas        = 8'(dwell_cnt[7:0] - 8'd1);
  assign match_inc   = 4'(match + 4'd1);

  // Dwell counter restarts at 1 on every phase change and saturates at 257,
  // one beyond the longest legal period, so a stall is unambiguous.
  always_comb begin
    dwell_next = dwell_cnt;
    if (phase_event) begin
      dwell_next = 9'd1;
    end else if (dwell_cnt != DWELL_SAT) begin
      dwell_next = 9'(dwell_cnt + 9'd1);
    end
  end

  // Rate-recovery state machine. Pulses default low every cycle; a stall is
  // raised on the same edge that the dwell counter reaches saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_q   <= 8'd0;
      dwell_cnt <= 9'd0;
      cand      <= 8'd0;
      match     <= 4'd0;
      freq_out  <= 8'd0;
      locked    <= 1'b0;
      freq_upd  <= 1'b0;
      step_err  <= 1'b0;
      stall     <= 1'b0;
    end else begin
      phase_q   <= phase_in;
      dwell_cnt <= dwell_next;
      freq_upd  <= 1'b0;
      step_err  <= 1'b0;

      if (phase_event) begin
        stall <= 1'b0;
        case (state)
          // The partial period seen before the first step is meaningless.
          IDLE: begin
            state <= ALIGN;
          end

          ALIGN: begin
            if (good_step) begin
              cand  <= meas;
              match <= 4'd1;
              if (LOCK_TARGET <= 4'd1) begin
                state    <= LOCKED;
                freq_out <= meas;
                locked   <= 1'b1;
                freq_upd <= 1'b1;
              end else begin
                state <= MEASURE;
              end
            end else begin
              step_err <= 1'b1;
            end
          end

          MEASURE: begin
            if (!good_step) begin
              step_err <= 1'b1;
              match    <= 4'd0;
              state    <= ALIGN;
            end else if (meas == cand) begin
              match <= match_inc;
              if (match_inc >= LOCK_TARGET) begin
                state    <= LOCKED;
                freq_out <= cand;
                locked   <= 1'b1;
                freq_upd <= 1'b1;
              end
            end else begin
              cand  <= meas;
              match <= 4'd1;
            end
          end

          LOCKED: begin
            if (!good_step) begin
              step_err <= 1'b1;
              locked   <= 1'b0;
              match    <= 4'd0;
              state    <= ALIGN;
            end else if (meas == freq_out) begin
              freq_upd <= 1'b1;
            end else begin
              locked <= 1'b0;
              cand   <= meas;
              match  <= 4'd1;
              state  <= MEASURE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end else if (dwell_cnt == DWELL_LAST) begin
        stall  <= 1'b1;
        locked <= 1'b0;
        match  <= 4'd0;
        state  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_phase_rate_detect.sv
// tb_phase_rate_detect
//
// Directed bench for phase_rate_detect with LOCK_COUNT=4. Stimulus tasks push
// the expected freq_upd/step_err pulse contents into a queue; a monitor pops
// one entry for every pulse the DUT raises and compares freq_out and locked.
// Level outputs (locked, freq_out, stall) are checked directly at key points.
module tb_phase_rate_detect;

  localparam int LOCK_COUNT = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] phase_in;
  logic [7:0] freq_out;
  logic       locked;
  logic       freq_upd;
  logic       step_err;
  logic       stall;

  typedef struct packed {
    logic       upd;
    logic       err;
    logic [7:0] freq;
    logic       lck;
  } exp_t;

  exp_t       expq[$];
  int         checks;
  int         failures;
  logic [7:0] cur;

  phase_rate_detect #(
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase_in (phase_in),
    .freq_out (freq_out),
    .locked   (locked),
    .freq_upd (freq_upd),
    .step_err (step_err),
    .stall    (stall)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Waits so that successive phase changes are 'gap' clocks apart, applies the
  // new phase, queues the pulse it should produce (if any) and returns on the
  // falling edge after the DUT has registered the event.
  task automatic applyStimulus(input int gap, input logic [7:0] nextPhase,
                               input logic expUpd, input logic expErr,
                               input logic [7:0] expFreq, input logic expLock);
    exp_t e;
    repeat (gap - 1) @(negedge clk);
    if (expUpd || expErr) begin
      e.upd  = expUpd;
      e.err  = expErr;
      e.freq = expFreq;
      e.lck  = expLock;
      expq.push_back(e);
    end
    phase_in = nextPhase;
    cur      = nextPhase;
    @(negedge clk);
  endtask

  // n good +1 steps at the given spacing; steps numbered firstUpd and later
  // are expected to produce a freq_upd with locked=1 and freq_out=f.
  task automatic stepRun(input int n, input int gap, input int firstUpd,
                         input logic [7:0] f);
    for (int i = 1; i <= n; i++) begin
      applyStimulus(gap, 8'(cur + 8'd1), (i >= firstUpd), 1'b0, f, (i >= firstUpd));
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (rst_n === 1'b1 && (freq_upd !== 1'b0 || step_err !== 1'b0)) begin
      got = {freq_upd, step_err, freq_out, locked};
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pulse: got upd=%b err=%b freq=%0d locked=%b expected no pulse",
                 freq_upd, step_err, freq_out, locked);
      end else begin
        want = expq.pop_front();
        if (got !== want) begin
          failures++;
          $display("[TB] FAIL pulse: got upd=%b err=%b freq=%0d locked=%b expected upd=%b err=%b freq=%0d locked=%b",
                   got.upd, got.err, got.freq, got.lck, want.upd, want.err, want.freq, want.lck);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    cur      = 8'd0;
    phase_in = 8'd0;
    rst_n    = 1'b0;

    #2;
    checkOutput("reset_freq_out", freq_out, 8'd0);
    checkOutput("reset_locked",   8'(locked),   8'd0);
    checkOutput("reset_freq_upd", 8'(freq_upd), 8'd0);
    checkOutput("reset_step_err", 8'(step_err), 8'd0);
    checkOutput("reset_stall",    8'(stall),    8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] F=3 lock from reset");
    stepRun(4, 4, 99, 8'd0);
    checkOutput("f3_not_locked_step4", 8'(locked), 8'd0);
    stepRun(1, 4, 1, 8'd3);
    checkOutput("f3_locked_step5", 8'(locked), 8'd1);
    checkOutput("f3_freq", freq_out, 8'd3);
    stepRun(2, 4, 1, 8'd3);

    $display("[TB] switch to F=7");
    stepRun(1, 8, 99, 8'd0);
    checkOutput("f7_unlock", 8'(locked), 8'd0);
    checkOutput("f7_freq_held", freq_out, 8'd3);
    stepRun(2, 8, 99, 8'd0);
    checkOutput("f7_still_unlocked", 8'(locked), 8'd0);
    stepRun(1, 8, 1, 8'd7);
    checkOutput("f7_relocked", 8'(locked), 8'd1);
    checkOutput("f7_freq", freq_out, 8'd7);
    stepRun(1, 8, 1, 8'd7);

    $display("[TB] +2 jump while locked");
    applyStimulus(8, 8'(cur + 8'd2), 1'b0, 1'b1, 8'd7, 1'b0);
    checkOutput("jump_unlock", 8'(locked), 8'd0);
    stepRun(1, 2, 99, 8'd0);
    stepRun(3, 8, 99, 8'd0);
    checkOutput("jump_unlocked_4good", 8'(locked), 8'd0);
    stepRun(1, 8, 1, 8'd7);
    checkOutput("jump_relocked_5good", 8'(locked), 8'd1);

    $display("[TB] F=0 across the wrap");
    applyStimulus(8, 8'd250, 1'b0, 1'b1, 8'd7, 1'b0);
    stepRun(3, 1, 99, 8'd0);
    checkOutput("f0_not_locked", 8'(locked), 8'd0);
    stepRun(6, 1, 1, 8'd0);
    checkOutput("f0_locked", 8'(locked), 8'd1);
    checkOutput("f0_freq", freq_out, 8'd0);
    checkOutput("f0_phase_wrapped", cur, 8'd3);

    $display("[TB] F=255 then stall");
    stepRun(1, 256, 99, 8'd0);
    checkOutput("f255_unlock", 8'(locked), 8'd0);
    checkOutput("f255_freq_held", freq_out, 8'd0);
    stepRun(2, 256, 99, 8'd0);
    stepRun(1, 256, 1, 8'd255);
    checkOutput("f255_locked", 8'(locked), 8'd1);
    checkOutput("f255_freq", freq_out, 8'd255);
    checkOutput("f255_no_stall", 8'(stall), 8'd0);
    repeat (254) @(negedge clk);
    checkOutput("stall_not_yet", 8'(stall), 8'd0);
    checkOutput("locked_before_stall", 8'(locked), 8'd1);
    repeat (4) @(negedge clk);
    checkOutput("stall_set", 8'(stall), 8'd1);
    checkOutput("stall_unlock", 8'(locked), 8'd0);
    checkOutput("stall_freq_held", freq_out, 8'd255);
    applyStimulus(1, 8'(cur + 8'd1), 1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("stall_cleared", 8'(stall), 8'd0);

    $display("[TB] relock then async reset");
    stepRun(3, 4, 99, 8'd0);
    stepRun(2, 4, 1, 8'd3);
    checkOutput("pre_reset_locked", 8'(locked), 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_freq_out", freq_out, 8'd0);
    checkOutput("areset_locked",   8'(locked),   8'd0);
    checkOutput("areset_freq_upd", 8'(freq_upd), 8'd0);
    checkOutput("areset_stall",    8'(stall),    8'd0);
    phase_in = 8'd0;
    cur      = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    stepRun(4, 4, 99, 8'd0);
    checkOutput("post_reset_not_locked", 8'(locked), 8'd0);
    stepRun(1, 4, 1, 8'd3);
    checkOutput("post_reset_locked", 8'(locked), 8'd1);
    checkOutput("post_reset_freq", freq_out, 8'd3);

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_pulses: got %0d outstanding expected 0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
